seq_detect_param: RTL and testbench

//   Parametrised Moore serial-pattern detector. Successor to the fixed 4-bit "1010" detector.
//   - Pattern and width are parameters.
//   - Input bits are qualified by a valid strobe; idle cycles do not advance the detector.
//   - Overlapping or non-overlapping matching is selected at run time.
//   - Optional saturating match counter.

---
 rtl/seq_detect_param.sv | 74 +++++++
 tb/tb_seq_detect_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with valid-qualified input and run-time overlap select.
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detect_param #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1010,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clear,
  input  logic             overlap,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned       FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_width
    $error("seq_detect_param: PAT_W must be in 2..16");
  end

  logic [PAT_W-1:0]  hist, hist_nxt, nh;
  logic [FILL_W-1:0] fill, fill_nxt, nf;
  logic              z_nxt;
  logic              hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
      z    <= z_nxt;
    end
  end

  // fill gates the compare, so stale history bits can never produce a hit.
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    z_nxt    = 1'b0;
    hit      = 1'b0;
    nh       = {hist[PAT_W-2:0], x};
    nf       = (fill == FULL) ? FULL : fill + FILL_W'(1);
    if (clear) begin
      fill_nxt = '0;
    end else if (x_valid) begin
      hit      = (nf == FULL) && (nh == PATTERN);
      hist_nxt = nh;
      z_nxt    = hit;
      fill_nxt = (hit && !overlap) ? '0 : nf;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
    end else if (clear) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: driver pushes model predictions, monitor pops and compares.
module tb_seq_detect_param;

  localparam int unsigned      PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1010;
  localparam int unsigned      CNT_W   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic             clear = 1'b0;
  logic             overlap = 1'b1;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic             exp_z_q[$];
  logic [CNT_W-1:0] exp_c_q[$];

  // Reference: list of accepted bits in the current window plus a plain match tally.
  int unsigned win[$];
  int unsigned mcnt = 0;

  seq_detect_param #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .overlap(overlap), .z(z), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic cnt_enabled();
`ifdef SEQDET_MATCH_CNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step(input logic xb, input logic v, input logic c,
                                     input logic ov, output logic ez,
                                     output logic [CNT_W-1:0] ec);
    logic [PAT_W-1:0] pat;
    logic             hit;
    pat = PATTERN;
    hit = 1'b0;
    if (c) begin
      win.delete();
      mcnt = 0;
    end else if (v) begin
      win.push_back(int'(xb));
      if (win.size() > PAT_W) void'(win.pop_front());
      if (win.size() == PAT_W) begin
        hit = 1'b1;
        for (int i = 0; i < int'(PAT_W); i++)
          if (win[i] != int'(pat[PAT_W-1-i])) hit = 1'b0;
      end
      if (hit) begin
        if (mcnt < (2 ** CNT_W) - 1) mcnt++;
        if (!ov) win.delete();
      end
    end
    ez = hit;
    ec = cnt_enabled() ? CNT_W'(mcnt) : '0;
  endfunction

  function automatic void model_reset();
    win.delete();
    mcnt = 0;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic xb, input logic v, input logic c, input logic ov);
    logic             ez;
    logic [CNT_W-1:0] ec;
    @(negedge clk);
    x = xb; x_valid = v; clear = c; overlap = ov;
    model_step(xb, v, c, ov, ez, ec);
    exp_z_q.push_back(ez);
    exp_c_q.push_back(ec);
  endtask

  task automatic bits(input logic [15:0] seq, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(seq[i], 1'b1, 1'b0, ov);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Async reset pulse inside the low phase of the clock, checked immediately.
  task automatic mid_reset();
    logic             ez;
    logic [CNT_W-1:0] ec;
    @(negedge clk);
    x = 1'b0; x_valid = 1'b0; clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_z", int'(z), 0);
    check("async_reset_cnt", int'(match_cnt), 0);
    model_reset();
    #1 reset = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, overlap, ez, ec);
    exp_z_q.push_back(ez);
    exp_c_q.push_back(ec);
  endtask

  initial begin : monitor
    logic             ez;
    logic [CNT_W-1:0] ec;
    forever begin
      @(posedge clk);
      #1;
      if (exp_z_q.size() > 0) begin
        ez = exp_z_q.pop_front();
        ec = exp_c_q.pop_front();
        check("z", int'(z), int'(ez));
        check("match_cnt", int'(match_cnt), int'(ec));
      end
    end
  end

  initial begin : driver
    repeat (2) @(negedge clk);
    check("reset_z", int'(z), 0);
    check("reset_cnt", int'(match_cnt), 0);
    reset = 1'b0;

    bits(16'b101010, 6, 1'b1);            // overlapping: two hits
    flush();
    bits(16'b101010, 6, 1'b0);            // non-overlapping: one hit
    flush();
    bits(16'b10, 2, 1'b1);                // idle gaps do not advance
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    bits(16'b10, 2, 1'b1);
    flush();
    bits(16'b101, 3, 1'b1);               // clear drops its own bit
    step(1'b0, 1'b1, 1'b1, 1'b1);
    bits(16'b1010, 4, 1'b1);
    flush();
    bits(16'b101, 3, 1'b1);               // reset mid-stream discards partial match
    mid_reset();
    bits(16'b0, 1, 1'b1);
    flush();
    bits(16'b1010, 4, 1'b1);              // counter saturation
    for (int r = 0; r < 4; r++) bits(16'b10, 2, 1'b1);
    bits(16'b1111, 4, 1'b1);              // all-ones window: no false hit

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    check("queue_drained", exp_z_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
